// File: rtl/lfsr_run_if.sv
// Requester-side bundle for the LFSR run controller.
// master = requester (control/test FSM), slave = controller.
interface lfsr_run_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic [WIDTH-1:0] seed;
    logic [CNT_W-1:0] steps;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic             error;

    modport master (
        output start, seed, steps,
        input  busy, done, q, error
    );

    modport slave (
        input  start, seed, steps,
        output busy, done, q, error
    );
endinterface

// File: rtl/lfsr_run_controller.sv
// Loads a seed into a Galois LFSR, advances it a programmed number of steps,
// then pulses done. Optional macro LFSR_ZERO_GUARD_EN substitutes 1 for a zero seed.
module lfsr_run_controller #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b0011,
    parameter int               CNT_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    lfsr_run_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_seed_ld;
    logic             w_seed_zero;

    // Galois step: shift left, fold the taps back in when the MSB falls out.
    assign w_next = {r_q[WIDTH-2:0], 1'b0} ^ (r_q[WIDTH-1] ? TAPS : '0);

    assign w_seed_zero = (bus.seed == '0);

`ifdef LFSR_ZERO_GUARD_EN
    // A zero seed would lock the LFSR up; start from 1 instead.
    assign w_seed_ld = w_seed_zero ? ONE : bus.seed;
`else
    assign w_seed_ld = bus.seed;
`endif

    // Run sequencer: capture on start, step while counting down, pulse done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_q     <= ONE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_q     <= w_seed_ld;
                        r_cnt   <= bus.steps;
                        r_error <= w_seed_zero;
                        if (bus.steps != '0) begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_q   <= w_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.q     = r_q;
    assign bus.error = r_error;
endmodule

// File: tb/tb_lfsr_run_controller.sv
// Self-checking bench for lfsr_run_controller (default parameters).
// Reference: position lookup in the published 15-state LFSR cycle.
module tb_lfsr_run_controller;
    logic clk = 1'b0;
    logic reset;

    int n_chk  = 0;
    int n_pass = 0;

    lfsr_run_if #(.WIDTH(4), .CNT_W(8)) bus ();

    lfsr_run_controller #(
        .WIDTH(4),
        .TAPS (4'b0011),
        .CNT_W(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // The maximal-length cycle starting from 0001.
    logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                             4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};

    function automatic logic [3:0] adv(input logic [3:0] s, input int n);
        int idx;
        idx = -1;
        for (int i = 0; i < 15; i++)
            if (seq[i] == s) idx = i;
        if (idx < 0) return s;
        return seq[(idx + n) % 15];
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One run; start pulsed once. poke>0 re-pulses start at that sample.
    task automatic do_run(input logic [3:0] sd, input logic [7:0] st,
                          input int poke);
        logic [3:0] eff;
        logic [3:0] fin;
        eff = sd;
`ifdef LFSR_ZERO_GUARD_EN
        if (sd == 4'h0) eff = 4'h1;
`endif
        fin = adv(eff, int'(st));
        @(negedge clk);
        bus.seed  = sd;
        bus.steps = st;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int j = 1; j <= int'(st) + 3; j++) begin
            if (j > 1) @(negedge clk);
            if (j <= int'(st)) begin
                check("busy_run", bus.busy, 1);
                check("done_run", bus.done, 0);
                check("q_run", bus.q, adv(eff, j - 1));
            end else if (j == int'(st) + 1) begin
                check("done_pulse", bus.done, 1);
                check("busy_done", bus.busy, 0);
                check("q_done", bus.q, fin);
                check("error", bus.error, (sd == 4'h0));
            end else begin
                check("done_after", bus.done, 0);
                check("busy_after", bus.busy, 0);
                check("q_hold", bus.q, fin);
            end
            if (j == poke) begin
                bus.start = 1'b1;
                bus.seed  = ~sd;
                bus.steps = 8'd1;
            end else begin
                bus.start = 1'b0;
            end
        end
    endtask

    initial begin
        logic [3:0] sd;
        logic [7:0] st;
        int         seen;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.seed  = 4'h0;
        bus.steps = 8'd0;
        repeat (5) @(negedge clk);
        check("rst_q", bus.q, 4'h1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_error", bus.error, 0);
        reset = 1'b0;

        do_run(4'h1, 8'd4, 0);
        do_run(4'h1, 8'd15, 0);
        do_run(4'hC, 8'd3, 0);
        do_run(4'h6, 8'd0, 0);
        do_run(4'h5, 8'd6, 3);
        do_run(4'h0, 8'd2, 0);
        do_run(4'h9, 8'd5, 0);
        do_run(4'hB, 8'd255, 0);

        // Start held high: a second run begins right after the DONE cycle.
        @(negedge clk);
        bus.seed  = 4'h2;
        bus.steps = 8'd1;
        bus.start = 1'b1;
        @(negedge clk);
        check("hold_busy1", bus.busy, 1);
        @(negedge clk);
        check("hold_done1", bus.done, 1);
        check("hold_q1", bus.q, 4'h4);
        @(negedge clk);
        check("hold_idle", bus.busy, 0);
        @(negedge clk);
        check("hold_rerun", bus.busy, 1);
        check("hold_reload", bus.q, 4'h2);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);

        // Reset two cycles into a long run aborts it with no done pulse.
        bus.seed  = 4'h7;
        bus.steps = 8'd10;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("pre_rst_q", bus.q, adv(4'h7, 1));
        reset = 1'b1;
        @(negedge clk);
        check("abort_q", bus.q, 4'h1);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        check("abort_quiet", seen, 0);
        check("abort_qhold", bus.q, 4'h1);

        // Randomized runs.
        for (int r = 0; r < 25; r++) begin
            sd = 4'($urandom_range(0, 15));
            if (sd == 4'h0 && r % 3 != 0) sd = 4'h3;
            st = 8'($urandom_range(0, 20));
            do_run(sd, st, (st > 3) ? int'($urandom_range(1, 2)) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
